// File: rtl/demux_scheduler.sv
// ---------------------------------------------------------------------------
// demux_scheduler
//
// Round-robin scheduler in front of a 1-to-8 demux. It arbitrates among eight
// level-sensitive requests and drives the demux select. It passes serial data
// only while a channel holds the grant. One guard cycle (GAP) separates any
// two grants, so the select never moves while data is flowing.
//
// Parameters
//   DWELL    maximum consecutive grant cycles per channel (1..256)
//
// Ports
//   clk      system clock; all state changes on the rising edge
//   rst      synchronous active-high reset; has priority over all inputs
//   req      per-channel request; bit i asks for demux output i
//   data_in  serial data to be steered
//   control  registered demux select
//   data     data_in while in GRANT, 0 otherwise (combinational gate)
//   grant    registered one-hot grant, 0 outside GRANT
//   busy     registered; high in GRANT and GAP
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant outstanding; arbitrate whenever any request is set
// GRANT | channel `control` owns the demux; data passes; dwell counts
// GAP   | single guard cycle after a grant; arbitrate for the next one
// ---------------------------------------------------------------------------
module demux_scheduler #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       data_in,
  output logic [2:0] control,
  output logic       data,
  output logic [7:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Terminal count of the dwell counter. DWELL=256 maps to 255, so the
  // 8-bit counter covers the whole legal range.
  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  state_t     state;
  logic [2:0] ptr;       // last channel served
  logic [7:0] cnt;       // grant cycles elapsed, minus one

  logic       arb_hit;
  logic [2:0] arb_idx;
  logic [2:0] cand;
  logic       grant_end;

  // Round-robin search. The loop visits the offsets from farthest to
  // nearest, and each hit overwrites the previous one. As a result, the
  // surviving index is the first set bit in the order ptr+1, ptr+2, ...,
  // ptr+8 (modulo 8). ptr+8 is ptr itself, which lets a sole requester win
  // again.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = 3'd0;
    cand    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i) + 3'd1;
      if (req[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  // Dwell expiry and request drop can coincide. Both feed a single exit
  // term, so ptr is updated only once.
  assign grant_end = (cnt == CNT_LAST) || !req[control];

  assign data = (state == GRANT) && data_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 3'd7;       // first search after reset starts at channel 0
      cnt     <= 8'd0;
      control <= 3'd0;
      grant   <= 8'd0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (arb_hit) begin
            state   <= GRANT;
            control <= arb_idx;
            grant   <= 8'd1 << arb_idx;
            cnt     <= 8'd0;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
            grant <= 8'd0;
            busy  <= 1'b0;
          end
        end

        GRANT: begin
          if (grant_end) begin
            state <= GAP;
            ptr   <= control;
            grant <= 8'd0;
            busy  <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: begin
          state <= IDLE;
          grant <= 8'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_scheduler.sv
module tb_demux_scheduler;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       data_in = 1'b0;
  logic [2:0] control;
  logic       data;
  logic [7:0] grant;
  logic       busy;

  demux_scheduler #(.DWELL(DWELL)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data_in (data_in),
    .control (control),
    .data    (data),
    .grant   (grant),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] g;
    logic [2:0] c;
    logic       b;
    logic       d;
  } exp_t;

  typedef struct {
    logic       r;
    logic [7:0] q;
    logic       din;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  int   order_q[$];
  int   nvec = 0;
  int   nmis = 0;
  int   cyc  = 0;
  logic [7:0] prev_grant = 8'h00;

  // Reference model state (0=IDLE, 1=GRANT, 2=GAP)
  int         m_state = 0;
  int         m_ptr   = 7;
  int         m_cnt   = 0;
  logic [7:0] m_grant = 8'h00;
  logic [2:0] m_ctl   = 3'd0;
  logic       m_busy  = 1'b0;

  function automatic exp_t model_step(input logic r, input logic [7:0] q, input logic din);
    exp_t e;
    int   w;
    if (r) begin
      m_state = 0; m_ptr = 7; m_cnt = 0;
      m_grant = 8'h00; m_ctl = 3'd0; m_busy = 1'b0;
    end else if (m_state == 1) begin
      if (m_cnt == DWELL - 1 || q[m_ctl] == 1'b0) begin
        m_ptr = int'(m_ctl); m_grant = 8'h00; m_busy = 1'b1; m_state = 2;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      w = -1;
      for (int k = 1; k <= 8; k++) begin
        if (w < 0 && q[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
      end
      if (w >= 0) begin
        m_state = 1; m_ctl = 3'(w); m_grant = 8'h01 << w; m_cnt = 0; m_busy = 1'b1;
      end else begin
        m_state = 0; m_grant = 8'h00; m_busy = 1'b0;
      end
    end
    e.g = m_grant;
    e.c = m_ctl;
    e.b = m_busy;
    e.d = (m_state == 1) ? din : 1'b0;
    return e;
  endfunction

  task automatic apply(input logic r, input logic [7:0] q, input logic din,
                       input logic use_tbl, input exp_t te);
    exp_t me;
    exp_t got;
    @(negedge clk);
    rst = r; req = q; data_in = din;
    me = model_step(r, q, din);
    exp_q.push_back(use_tbl ? te : me);
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() == 0) begin
      nvec++; nmis++;
      $display("FAIL scoreboard cyc%0d: got empty queue, required one entry", cyc);
    end else begin
      got = exp_q.pop_front();
      nvec++;
      if (grant !== got.g || control !== got.c || busy !== got.b || data !== got.d) begin
        nmis++;
        $display("FAIL outputs cyc%0d: got grant=%h control=%0d busy=%b data=%b, required grant=%h control=%0d busy=%b data=%b",
                 cyc, grant, control, busy, data, got.g, got.c, got.b, got.d);
      end
    end
    if (prev_grant == 8'h00 && grant != 8'h00) order_q.push_back(int'(control));
    prev_grant = grant;
  endtask

  task automatic step(input logic r, input logic [7:0] q);
    exp_t dummy;
    dummy = '{g: 8'h00, c: 3'd0, b: 1'b0, d: 1'b0};
    apply(r, q, 1'($urandom_range(0, 1)), 1'b0, dummy);
  endtask

  task automatic check_order(input string nm, input int n, input int e[9]);
    nvec++;
    if (order_q.size() < n) begin
      nmis++;
      $display("FAIL %s: got %0d grants, required at least %0d", nm, order_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (order_q[i] != e[i]) begin
          nmis++;
          $display("FAIL %s: grant #%0d got channel %0d, required %0d", nm, i, order_q[i], e[i]);
          break;
        end
      end
    end
  endtask

  vec_t tbl[11];

  initial begin
    // Reset with all requests high, then a single requester on channel 3.
    //           rst  req    din   grant  ctl  busy data
    tbl[0]  = '{1'b1, 8'hFF, 1'b1, '{8'h00, 3'd0, 1'b0, 1'b0}};
    tbl[1]  = '{1'b1, 8'hFF, 1'b1, '{8'h00, 3'd0, 1'b0, 1'b0}};
    tbl[2]  = '{1'b0, 8'h08, 1'b0, '{8'h08, 3'd3, 1'b1, 1'b0}};
    tbl[3]  = '{1'b0, 8'h08, 1'b1, '{8'h08, 3'd3, 1'b1, 1'b1}};
    tbl[4]  = '{1'b0, 8'h08, 1'b0, '{8'h08, 3'd3, 1'b1, 1'b0}};
    tbl[5]  = '{1'b0, 8'h08, 1'b1, '{8'h08, 3'd3, 1'b1, 1'b1}};
    tbl[6]  = '{1'b0, 8'h08, 1'b1, '{8'h00, 3'd3, 1'b1, 1'b0}};
    tbl[7]  = '{1'b0, 8'h08, 1'b1, '{8'h08, 3'd3, 1'b1, 1'b1}};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, '{8'h00, 3'd3, 1'b1, 1'b0}};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, '{8'h00, 3'd3, 1'b0, 1'b0}};
    tbl[10] = '{1'b0, 8'h00, 1'b0, '{8'h00, 3'd3, 1'b0, 1'b0}};

    for (int i = 0; i < 11; i++) apply(tbl[i].r, tbl[i].q, tbl[i].din, 1'b1, tbl[i].e);

    // Full load: channels 0..7 then 0, one zero-grant cycle between each.
    step(1'b1, 8'hFF);
    step(1'b1, 8'hFF);
    order_q.delete();
    for (int i = 0; i < 46; i++) step(1'b0, 8'hFF);
    check_order("full_load_order", 9, '{0, 1, 2, 3, 4, 5, 6, 7, 0});

    // Early release: serve channel 4 first so that channel 5 wins next.
    step(1'b1, 8'h00);
    step(1'b0, 8'h10);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    order_q.delete();
    step(1'b0, 8'h64);
    step(1'b0, 8'h64);
    step(1'b0, 8'h44);           // req[5] drops in the 2nd grant cycle
    for (int i = 0; i < 14; i++) step(1'b0, 8'h44);
    check_order("early_release_order", 3, '{5, 6, 2, 0, 0, 0, 0, 0, 0});

    // Wrap: channel 7 served, then 0, then 7 again.
    step(1'b1, 8'h00);
    order_q.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h80);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h81);
    check_order("wrap_order", 3, '{7, 0, 7, 0, 0, 0, 0, 0, 0});

    // Reset during the 3rd grant cycle of channel 4.
    step(1'b1, 8'h00);
    step(1'b0, 8'h10);
    step(1'b0, 8'h10);
    step(1'b0, 8'h10);
    step(1'b1, 8'hFF);
    order_q.delete();
    for (int i = 0; i < 12; i++) step(1'b0, 8'hFF);
    check_order("reset_mid_grant_order", 2, '{0, 1, 0, 0, 0, 0, 0, 0, 0});

    // Random traffic against the model.
    step(1'b1, 8'h00);
    for (int i = 0; i < 300; i++) begin
      logic [7:0] q;
      q = 8'($urandom) & 8'($urandom);
      step(1'($urandom_range(0, 99) == 0), q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
